instruction_fetch: RTL

Instruction-fetch (IF) stage of the 5-stage DLX pipeline. It holds the PC, issues requests to instruction memory over a valid/ready handshake, and drives the IF/ID pipeline register consumed by the decode stage (`nextPC` and `instruction`). It also absorbs decode back-pressure with a one-entry buffer and honours branch/jump redirects with a flush.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if_id_register.sv | 58 +++++
 rtl/instruction_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the DLX instruction-fetch stage.
// Holds the NOP encoding, the reset PC and the IF state encodings so that
// decode/hazard logic and benches agree on them.
package instruction_fetch_pkg;

    localparam logic [31:0] NopInstr = 32'h5400_0000;  // DLX nop
    localparam logic [31:0] ResetPc  = 32'h0000_0000;

    // IF state encodings
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StDrop  = 2'd3;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: {instruction, nextPC, valid}.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          capture instr_i/npc_i and mark valid
//   flush_i         inject NOP, nextPC 0, valid 0 (wins over load_i)
//   instr_i, npc_i  incoming instruction and its PC+4
//   instr_o, npc_o, valid_o  registered IF/ID contents
module instruction_fetch_if_id_register #(
    parameter int unsigned SIZE = 32,
    parameter logic [SIZE-1:0] NOP = SIZE'(instruction_fetch_pkg::NopInstr)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [SIZE-1:0] instr_i,
    input  logic [SIZE-1:0] npc_i,
    output logic [SIZE-1:0] instr_o,
    output logic [SIZE-1:0] npc_o,
    output logic            valid_o
);

    logic [SIZE-1:0] instr_q, instr_d;
    logic [SIZE-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= NOP;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// DLX instruction-fetch stage: PC, imem valid/ready requester, one-entry
// back-pressure buffer and redirect/flush handling, feeding the IF/ID register.
// Ports:
//   clk, reset (async active-low)
//   stall                 decode cannot accept IF/ID this cycle
//   redirect, redirect_pc branch/jump taken and its target (bits [1:0] ignored)
//   imem_req, imem_addr   fetch request and word-aligned address
//   imem_ready, imem_rdata memory completion and returned instruction
//   nextPC_out, instruction_out, valid_out  IF/ID contents
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = SIZE'(ResetPc),
    parameter logic [SIZE-1:0] NOP      = SIZE'(NopInstr)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [SIZE-1:0] redirect_pc,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [SIZE-1:0] imem_rdata,
    output logic [SIZE-1:0] nextPC_out,
    output logic [SIZE-1:0] instruction_out,
    output logic            valid_out
);

    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0] buf_instr_q, buf_instr_d;
    logic [SIZE-1:0] buf_npc_q, buf_npc_d;
    logic [SIZE-1:0] pend_q, pend_d;

    logic            ifid_load, ifid_flush;
    logic [SIZE-1:0] ifid_instr, ifid_npc;

    logic [SIZE-1:0] pc_plus4;
    logic [SIZE-1:0] target;
    logic            complete;

    assign pc_plus4 = pc_q + SIZE'(4);  // wraps modulo 2^SIZE
    assign target   = redirect_pc & ~SIZE'(3);
    assign imem_req = (state_q == StFetch) || (state_q == StDrop);
    assign imem_addr = pc_q;
    assign complete = imem_req && imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_npc_d   = buf_npc_q;
        pend_d      = pend_q;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_instr  = imem_rdata;
        ifid_npc    = pc_plus4;

        if (redirect) begin
            ifid_flush = 1'b1;
            // An outstanding request cannot be cancelled: park the target
            // until the stale completion has been absorbed.
            if ((state_q == StFetch || state_q == StDrop) && !complete) begin
                pend_d  = target;
                state_d = StDrop;
            end else begin
                pc_d    = target;
                state_d = StFetch;
            end
        end else begin
            case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (complete) begin
                        if (stall) begin
                            buf_instr_d = imem_rdata;
                            buf_npc_d   = pc_plus4;
                            state_d     = StHold;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = buf_instr_q;
                        ifid_npc   = buf_npc_q;
                        pc_d       = pc_plus4;
                        state_d    = StFetch;
                    end
                end
                StDrop: begin
                    if (complete) begin
                        pc_d    = pend_q;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            buf_instr_q <= NOP;
            buf_npc_q   <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_npc_q   <= buf_npc_d;
            pend_q      <= pend_d;
        end
    end

    instruction_fetch_if_id_register #(
        .SIZE (SIZE),
        .NOP  (NOP)
    ) u_if_id (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (ifid_instr),
        .npc_i   (ifid_npc),
        .instr_o (instruction_out),
        .npc_o   (nextPC_out),
        .valid_o (valid_out)
    );

endmodule
